subn_serial: RTL

//   Bit-serial N-bit subtractor: diff = a - b, LSB first, one bit per clock through a

---
 rtl/subn_serial.sv | 90 +++++++++
 1 files changed

// File: rtl/subn_serial.sv
// Bit-serial N-bit subtractor: one full-subtractor cell, LSB first, registered borrow,
// valid/ready handshakes on operand and result sides.
module subn_serial #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         ovf
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_sr, b_sr, diff_shift;
  logic [CW-1:0]  count;
  logic           br, br_nxt, a0, b0, d, last;

  assign a0     = a_sr[0];
  assign b0     = b_sr[0];
  assign d      = a0 ^ b0 ^ br;
  assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign last   = (count == CW'(N - 1));

  // New result bit enters at the MSB so diff is aligned after N shifts.
  generate
    if (N == 1) begin : g_one
      assign diff_shift = d;
    end else begin : g_many
      assign diff_shift = {d, diff[N-1:1]};
    end
  endgenerate

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      diff   <= '0;
      count  <= '0;
      br     <= 1'b0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= a;
          b_sr  <= b;
          br    <= 1'b0;
          count <= '0;
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          diff  <= diff_shift;
          br    <= br_nxt;
          count <= count + CW'(1);
          // On the last edge a0/b0 are the operand sign bits and d is the result sign.
          if (last) begin
            borrow <= br_nxt;
            ovf    <= (a0 ^ b0) & (d ^ a0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
